// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer scoreboard producing the single ID/IF stall.
// Handles variable-latency loads, a multi-cycle mul/div unit and branch-in-ID operands.
module hazard_scoreboard #(
   parameter int NREG         = 32,
   parameter int AW           = 5,
   parameter int BRANCH_IN_ID = 1,
   parameter int FWD_EN       = 1,
   parameter int CNTW         = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rs1,
   input  logic [AW-1:0]   id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic            id_is_branch,
   input  logic            id_regwrite,
   input  logic [AW-1:0]   id_rd,
   input  logic [1:0]      id_kind,
   input  logic            id_flush,
   input  logic            ld_done,
   input  logic [AW-1:0]   ld_rd,
   input  logic            md_done,
   input  logic [AW-1:0]   md_rd,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic            stall,
   output logic            md_busy,
   output logic [NREG-1:0] busy_vec
);

   localparam logic [1:0] K_ALU = 2'b00;
   localparam logic [1:0] K_LD  = 2'b01;
   localparam logic [1:0] K_MD  = 2'b10;

   logic [CNTW-1:0] cnt_q  [NREG];
   logic [1:0]      kind_q [NREG];
   logic [1:0]      age_q  [NREG];
   logic [NREG-1:0] done_q;
   logic            md_busy_q;

   logic [NREG-1:0] iss_hit;
   logic [NREG-1:0] wb_hit;
   logic [NREG-1:0] ld_hit;
   logic [NREG-1:0] md_hit;
   logic [1:0]      src_hz;
   logic [1:0]      iss_kind;
   logic            issue;
   logic            issue_wr;
   logic            waw_hz;
   logic            md_hz;
   logic            full_hz;

   // Reserved kind behaves exactly like ALU, so fold it at issue.
   assign iss_kind = (id_kind == 2'b11) ? K_ALU : id_kind;
   assign issue    = id_valid && !stall && !id_flush;
   assign issue_wr = issue && id_regwrite && (id_rd != '0);

   always_comb begin
      wb_hit = '0;
      ld_hit = '0;
      md_hit = '0;
      for (int r = 1; r < NREG; r++) begin
         wb_hit[r] = wb_valid && (wb_rd == AW'(r)) && (cnt_q[r] != '0);
         ld_hit[r] = ld_done && (ld_rd == AW'(r)) && (kind_q[r] == K_LD);
         md_hit[r] = md_done && (md_rd == AW'(r)) && (kind_q[r] == K_MD);
      end
   end

   always_comb begin
      iss_hit = '0;
      for (int r = 1; r < NREG; r++)
         iss_hit[r] = issue_wr && (id_rd == AW'(r));
   end

   for (genvar g = 0; g < 2; g++) begin : g_src
      logic [AW-1:0] s;
      logic          u;
      logic          busy;
      logic          slow;
      logic          now;
      logic          last;
      assign s    = (g == 0) ? id_rs1 : id_rs2;
      assign u    = (g == 0) ? id_use_rs1 : id_use_rs2;
      assign busy = u && (s != '0) && (cnt_q[s] != '0);
      assign slow = (kind_q[s] == K_LD) || (kind_q[s] == K_MD);
      assign now  = ld_hit[s] || md_hit[s];
      // Register file writes early, so the final WB cycle is readable.
      assign last = wb_hit[s] && (cnt_q[s] == CNTW'(1));
      if (FWD_EN == 0) begin : g_nofwd
         assign src_hz[g] = busy && !last;
      end else if (BRANCH_IN_ID != 0) begin : g_brid
         assign src_hz[g] = busy && (id_is_branch ?
            (((kind_q[s] == K_ALU) && (age_q[s] == 2'd0)) ||
             (slow && (!done_q[s] || now))) :
            (slow && !done_q[s] && !now));
      end else begin : g_brex
         assign src_hz[g] = busy && slow && !done_q[s] && !now;
      end
   end

   assign waw_hz = id_regwrite && (id_rd != '0) && (cnt_q[id_rd] != '0) &&
                   ((kind_q[id_rd] == K_LD) || (kind_q[id_rd] == K_MD)) &&
                   !done_q[id_rd];
   assign md_hz   = (id_kind == K_MD) && md_busy_q && !md_done;
   assign full_hz = id_regwrite && (cnt_q[id_rd] == '1);

   assign stall = id_valid && !id_flush &&
                  ((|src_hz) || waw_hz || md_hz || full_hz);

   assign md_busy = md_busy_q;

   always_comb begin
      busy_vec = '0;
      for (int r = 1; r < NREG; r++)
         busy_vec[r] = (cnt_q[r] != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r]  <= '0;
            kind_q[r] <= K_ALU;
            age_q[r]  <= 2'd0;
         end
         done_q    <= '0;
         md_busy_q <= 1'b0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (iss_hit[r]) begin
               if (!wb_hit[r])
                  cnt_q[r] <= cnt_q[r] + CNTW'(1);
               kind_q[r] <= iss_kind;
               age_q[r]  <= 2'd0;
               done_q[r] <= (iss_kind == K_ALU);
            end else if (wb_hit[r] && (cnt_q[r] == CNTW'(1))) begin
               cnt_q[r]  <= '0;
               kind_q[r] <= K_ALU;
               age_q[r]  <= 2'd0;
               done_q[r] <= 1'b0;
            end else begin
               if (wb_hit[r])
                  cnt_q[r] <= cnt_q[r] - CNTW'(1);
               if ((cnt_q[r] != '0) && (age_q[r] != 2'd3))
                  age_q[r] <= age_q[r] + 2'd1;
               if (ld_hit[r] || md_hit[r])
                  done_q[r] <= 1'b1;
            end
         end
         if (issue && (id_kind == K_MD))
            md_busy_q <= 1'b1;
         else if (md_done)
            md_busy_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: default, branch-in-EX and
// no-forwarding builds share one stimulus stream.
module tb_hazard_scoreboard;

   localparam logic [1:0] ALU = 2'b00;
   localparam logic [1:0] LD  = 2'b01;
   localparam logic [1:0] MD  = 2'b10;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        id_is_branch;
   logic        id_regwrite;
   logic [4:0]  id_rd;
   logic [1:0]  id_kind;
   logic        id_flush;
   logic        ld_done;
   logic [4:0]  ld_rd;
   logic        md_done;
   logic [4:0]  md_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;

   logic        stall0, stall1, stall2;
   logic        mdb0, mdb1, mdb2;
   logic [31:0] bv0, bv1, bv2;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_scoreboard u0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_branch(id_is_branch), .id_regwrite(id_regwrite),
      .id_rd(id_rd), .id_kind(id_kind), .id_flush(id_flush),
      .ld_done(ld_done), .ld_rd(ld_rd), .md_done(md_done), .md_rd(md_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall(stall0), .md_busy(mdb0), .busy_vec(bv0));

   hazard_scoreboard #(.BRANCH_IN_ID(0)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_branch(id_is_branch), .id_regwrite(id_regwrite),
      .id_rd(id_rd), .id_kind(id_kind), .id_flush(id_flush),
      .ld_done(ld_done), .ld_rd(ld_rd), .md_done(md_done), .md_rd(md_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall(stall1), .md_busy(mdb1), .busy_vec(bv1));

   hazard_scoreboard #(.FWD_EN(0)) u2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_branch(id_is_branch), .id_regwrite(id_regwrite),
      .id_rd(id_rd), .id_kind(id_kind), .id_flush(id_flush),
      .ld_done(ld_done), .ld_rd(ld_rd), .md_done(md_done), .md_rd(md_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall(stall2), .md_busy(mdb2), .busy_vec(bv2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_all();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_is_branch = 0; id_regwrite = 0; id_rd = 0; id_kind = ALU;
      id_flush = 0; ld_done = 0; ld_rd = 0; md_done = 0; md_rd = 0;
      wb_valid = 0; wb_rd = 0;
   endtask

   task automatic id_drv(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic br, input logic rw,
                         input logic [4:0] rd, input logic [1:0] kind);
      id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
      id_use_rs2 = u2; id_is_branch = br; id_regwrite = rw;
      id_rd = rd; id_kind = kind;
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic do_rst();
      clr_all();
      rst = 1;
      nxt();
      rst = 0;
   endtask

   initial begin
      clr_all();
      rst = 1;
      #3;
      id_drv(5, 1, 6, 1, 1, 1, 7, MD);
      #1;
      chk("rst_stall", {31'd0, stall0}, 0);
      chk("rst_mdbusy", {31'd0, mdb0}, 0);
      chk("rst_busy", bv0, 0);

      // lw x5 ; add x6,x5,x1 with load returning 5 cycles after issue
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 5, LD);
      #1 chk("lw_issue", {31'd0, stall0}, 0);
      for (int c = 1; c <= 4; c++) begin
         nxt();
         id_drv(5, 1, 1, 1, 0, 1, 6, ALU);
         if (c == 1) begin
            id_flush = 1;
            #1 chk("flush_nostall", {31'd0, stall0}, 0);
            id_flush = 0;
         end
         #1 chk("ld_use_stall", {31'd0, stall0}, 1);
      end
      nxt();
      ld_done = 1; ld_rd = 5;
      #1 chk("ld_done_cyc", {31'd0, stall0}, 0);
      nxt();
      clr_all();
      #1 chk("ld_busyvec", bv0, 32'h0000_0060);

      // addi x7 ; beq x7,x0
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 7, ALU);
      nxt();
      id_drv(7, 1, 0, 1, 1, 0, 0, ALU);
      #1 chk("br_alu_id", {31'd0, stall0}, 1);
      chk("br_alu_ex", {31'd0, stall1}, 0);
      nxt();
      #1 chk("br_alu_age1", {31'd0, stall0}, 0);

      // lw x8 ; beq x8,x0 with load data in the second ID cycle
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 8, LD);
      nxt();
      id_drv(8, 1, 0, 1, 1, 0, 0, ALU);
      #1 chk("br_ld_c1", {31'd0, stall0}, 1);
      nxt();
      ld_done = 1; ld_rd = 8;
      #1 chk("br_ld_c2", {31'd0, stall0}, 1);
      chk("br_ld_c2_ex", {31'd0, stall1}, 0);
      nxt();
      ld_done = 0;
      #1 chk("br_ld_c3", {31'd0, stall0}, 0);

      // mul x9 ; mul x11 (structural) ; div x11 (WAW)
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 9, MD);
      #1 chk("mul_first", {31'd0, stall0}, 0);
      nxt();
      id_drv(2, 1, 0, 0, 0, 1, 11, MD);
      #1 chk("md_busy_set", {31'd0, mdb0}, 1);
      chk("md_struct1", {31'd0, stall0}, 1);
      nxt();
      #1 chk("md_struct2", {31'd0, stall0}, 1);
      nxt();
      md_done = 1; md_rd = 9;
      #1 chk("md_done_cyc", {31'd0, stall0}, 0);
      nxt();
      md_done = 0;
      #1 chk("md_busy_hold", {31'd0, mdb0}, 1);
      chk("waw_struct", {31'd0, stall0}, 1);
      nxt();
      md_done = 1; md_rd = 11;
      #1 chk("waw_done_cyc", {31'd0, stall0}, 1);
      nxt();
      md_done = 0;
      #1 chk("md_busy_clr", {31'd0, mdb0}, 0);
      chk("waw_clear", {31'd0, stall0}, 0);
      nxt();
      clr_all();
      #1 chk("md_busy_reissue", {31'd0, mdb0}, 1);
      chk("md_busyvec", bv0, 32'h0000_0A00);

      // no-forwarding build: add x3 ; sub x4,x3,x3
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 3, ALU);
      nxt();
      id_drv(3, 1, 3, 1, 0, 1, 4, ALU);
      #1 chk("nofwd_c1", {31'd0, stall2}, 1);
      chk("fwd_alu_c1", {31'd0, stall0}, 0);
      nxt();
      #1 chk("nofwd_c2", {31'd0, stall2}, 1);
      nxt();
      wb_valid = 1; wb_rd = 3;
      #1 chk("nofwd_wbcyc", {31'd0, stall2}, 0);
      chk("nofwd_bv3_wb", {31'd0, bv2[3]}, 1);
      nxt();
      clr_all();
      #1 chk("nofwd_bv3_after", {31'd0, bv2[3]}, 0);
      chk("nofwd_bv4", {31'd0, bv2[4]}, 1);

      // two writers to x10, idle-target events, saturation, async reset
      do_rst();
      id_drv(0, 0, 0, 0, 0, 1, 10, ALU);
      nxt();
      #1 chk("x10_second", {31'd0, stall0}, 0);
      nxt();
      clr_all();
      #1 chk("x10_cnt2", bv0, 32'h0000_0400);
      wb_valid = 1; wb_rd = 10;
      nxt();
      #1 chk("x10_cnt1", bv0, 32'h0000_0400);
      nxt();
      ld_done = 1; ld_rd = 10;
      #1 chk("x10_cnt0", bv0, 0);
      nxt();
      clr_all();
      #1 chk("x10_no_uflow", bv0, 0);
      id_drv(0, 0, 0, 0, 0, 1, 10, ALU);
      nxt();
      nxt();
      nxt();
      #1 chk("cnt_full", {31'd0, stall0}, 1);
      id_drv(0, 0, 0, 0, 0, 1, 13, MD);
      #1 chk("mul13", {31'd0, stall0}, 0);
      nxt();
      id_drv(0, 0, 0, 0, 0, 1, 15, MD);
      #1 chk("pre_rst_stall", {31'd0, stall0}, 1);
      chk("pre_rst_busy", bv0, 32'h0000_2400);
      rst = 1;
      #1 chk("async_rst_busy", bv0, 0);
      chk("async_rst_md", {31'd0, mdb0}, 0);
      chk("async_rst_stall", {31'd0, stall0}, 0);
      nxt();
      rst = 0;
      clr_all();
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
